// File: rtl/axis_video_pattern_gen.sv
// axis_video_pattern_gen
//   AXI4-Stream synthetic RGB frame source. Walks an x/y raster and emits one
//   pixel per accepted beat; tuser marks (0,0), tlast marks the end of a line.
//   Pattern is latched at frame start, so mid-frame pattern_sel changes only
//   affect the next frame. Frames are never truncated by enable dropping.
//
//   Optional build macro PATGEN_LINE_GAP_EN: inserts LINE_GAP idle cycles
//   (tvalid=0) after every accepted tlast beat, including at frame end.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   enable            start / continue frame generation
//   pattern_sel[1:0]  0 solid ch0, 1 h-ramp, 2 v-ramp, 3 8x8 checkerboard
//   m_axis_*          AXI4-Stream master (tdata = {ch2,ch1,ch0})
//   frame_done        1-cycle pulse after the final beat of a frame is taken
//   frame_cnt[15:0]   completed frame count, wraps
module axis_video_pattern_gen #(
  parameter int PXL_D_WIDTH = 8,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int LINE_GAP    = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic [1:0]                 pattern_sel,
  output logic [3*PXL_D_WIDTH-1:0]   m_axis_tdata,
  output logic                       m_axis_tvalid,
  output logic                       m_axis_tuser,
  output logic                       m_axis_tlast,
  input  logic                       m_axis_tready,
  output logic                       frame_done,
  output logic [15:0]                frame_cnt
);

  localparam int XW = $clog2(H_ACTIVE);
  localparam int YW = $clog2(V_ACTIVE);

  if (H_ACTIVE < 2 || V_ACTIVE < 2 || LINE_GAP < 1 ||
      PXL_D_WIDTH < 1 || PXL_D_WIDTH > 32) begin : g_param_check
    $error("axis_video_pattern_gen: illegal parameter value");
  end

  typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_t;

  state_t          state;
  logic [XW-1:0]   x;
  logic [YW-1:0]   y;
  logic [1:0]      pat;
  logic            x_last, y_last;

`ifdef PATGEN_LINE_GAP_EN
  localparam int GW = $clog2(LINE_GAP + 1);
  logic [GW-1:0]   gap_cnt;
  logic            frame_end;   // the gap being served follows the last line
`endif

  assign x_last = (x == XW'(H_ACTIVE - 1));
  assign y_last = (y == YW'(V_ACTIVE - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      x          <= '0;
      y          <= '0;
      pat        <= '0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
`ifdef PATGEN_LINE_GAP_EN
      gap_cnt    <= '0;
      frame_end  <= 1'b0;
`endif
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: if (enable) begin
          pat   <= pattern_sel;
          x     <= '0;
          y     <= '0;
          state <= ACTIVE;
        end
        // tvalid is constantly high here, so tready alone means acceptance
        ACTIVE: if (m_axis_tready) begin
          if (x_last) begin
            x <= '0;
            y <= y_last ? '0 : y + 1'b1;
            if (y_last) begin
              frame_cnt  <= frame_cnt + 16'd1;
              frame_done <= 1'b1;
            end
`ifdef PATGEN_LINE_GAP_EN
            frame_end <= y_last;
            gap_cnt   <= '0;
            state     <= GAP;
`else
            if (y_last) begin
              if (enable) pat   <= pattern_sel;  // back-to-back frame
              else        state <= IDLE;
            end
`endif
          end else begin
            x <= x + 1'b1;
          end
        end
`ifdef PATGEN_LINE_GAP_EN
        // enable / pattern are sampled at the end of the frame-end gap
        GAP: if (gap_cnt == GW'(LINE_GAP - 1)) begin
          if (!frame_end) begin
            state <= ACTIVE;
          end else if (enable) begin
            pat   <= pattern_sel;
            state <= ACTIVE;
          end else begin
            state <= IDLE;
          end
        end else begin
          gap_cnt <= gap_cnt + 1'b1;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  // Beat contents are pure functions of the registered raster position, so
  // they hold stable for free while the sink stalls.
  logic [PXL_D_WIDTH-1:0] gray;
  logic                   chk_bit;

  assign m_axis_tvalid = (state == ACTIVE);
  assign m_axis_tuser  = m_axis_tvalid && (x == '0) && (y == '0);
  assign m_axis_tlast  = m_axis_tvalid && x_last;
  // bit 3 via shift so narrow rasters (XW/YW <= 3) still elaborate
  assign chk_bit = 1'(32'(x) >> 3) ^ 1'(32'(y) >> 3);

  always_comb begin
    gray         = '0;
    m_axis_tdata = '0;
    case (pat)
      2'd1:    gray = PXL_D_WIDTH'(x);
      2'd2:    gray = PXL_D_WIDTH'(y);
      2'd3:    gray = chk_bit ? {PXL_D_WIDTH{1'b1}} : '0;
      default: gray = '0;
    endcase
    if (m_axis_tvalid) begin
      if (pat == 2'd0) m_axis_tdata = {{(2*PXL_D_WIDTH){1'b0}}, {PXL_D_WIDTH{1'b1}}};
      else             m_axis_tdata = {gray, gray, gray};
    end
  end

endmodule

// File: tb/tb_axis_video_pattern_gen.sv
// Directed bench for axis_video_pattern_gen on a 16x16 raster: contiguous and
// randomly stalled frames, all four patterns, back-to-back frames with mid-
// frame pattern_sel / enable changes, and asynchronous reset mid-frame.
module tb_axis_video_pattern_gen;
  localparam int PW = 8;
  localparam int H  = 16;
  localparam int V  = 16;
  localparam int LG = 4;
`ifdef PATGEN_LINE_GAP_EN
  localparam int GAPC = LG;
`else
  localparam int GAPC = 0;
`endif

  logic            clk, rst_n, enable;
  logic [1:0]      pattern_sel;
  logic [3*PW-1:0] m_axis_tdata;
  logic            m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tready;
  logic            frame_done;
  logic [15:0]     frame_cnt;

  int total  = 0;
  int passed = 0;
  int failed = 0;
  int cyc;
  int fcnt   = 0;

  axis_video_pattern_gen #(
    .PXL_D_WIDTH(PW), .H_ACTIVE(H), .V_ACTIVE(V), .LINE_GAP(LG)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pattern_sel(pattern_sel),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(m_axis_tready), .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [23:0] pix(input logic [1:0] p, input int x, input int y);
    case (p)
      2'd0:    return 24'h0000FF;
      2'd1:    return {3{x[7:0]}};
      2'd2:    return {3{y[7:0]}};
      default: return (x[3] ^ y[3]) ? 24'hFFFFFF : 24'h000000;
    endcase
  endfunction

  // Walks one frame from the current post-edge point. lead = idle cycles
  // expected before the first beat; at accepted beat ev_at, enable and
  // pattern_sel are driven to ev_en / ev_pat. Returns with the final beat
  // accepted on the last edge.
  task automatic run_frame(input logic [1:0] p, input bit rnd, input int lead,
                           input int ev_at, input bit ev_en, input logic [1:0] ev_pat,
                           output int ncyc);
    int bx, by, beat, gap;
    bx = 0; by = 0; beat = 0; gap = lead; ncyc = 0;
    while (by < V && ncyc < 5000) begin
      m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (ncyc == 1) chk("done_clr", 64'(frame_done), 64'd0);
      if (gap > 0) begin
        chk("gap_idle", 64'(m_axis_tvalid), 64'd0);
        gap--;
      end else begin
        chk("beat", {m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata},
            {1'b1, (bx == 0 && by == 0), (bx == H - 1), pix(p, bx, by)});
        if (m_axis_tready) begin
          if (beat == ev_at) begin enable = ev_en; pattern_sel = ev_pat; end
          beat++;
          if (bx == H - 1) begin bx = 0; by++; gap = GAPC; end
          else bx++;
        end
      end
      tick();
      ncyc++;
    end
    if (by < V) chk("frame_timeout", 64'(by), 64'(V));
    m_axis_tready = 1'b1;
  endtask

  task automatic end_of_frame(input string tag);
    fcnt++;
    chk({tag, "_done"}, 64'(frame_done), 64'd1);
    chk({tag, "_cnt"}, 64'(frame_cnt), 64'(fcnt));
  endtask

  task automatic idle_chk(input string tag);
    repeat (GAPC + 2) tick();
    chk(tag, {frame_done, m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata}, 64'd0);
  endtask

  initial begin
    clk = 0; rst_n = 0; enable = 0; pattern_sel = 2'd0; m_axis_tready = 1'b0;
    #12;
    chk("rst_out", {frame_done, m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata}, 64'd0);
    chk("rst_cnt", 64'(frame_cnt), 64'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    m_axis_tready = 1'b1;
    idle_chk("idle_no_en");

    // horizontal ramp, enable pulsed for one cycle, sink always ready
    pattern_sel = 2'd1; enable = 1'b1; tick(); enable = 1'b0;
    run_frame(2'd1, 1'b0, 0, -1, 1'b0, 2'd0, cyc);
    end_of_frame("hramp");
    chk("hramp_cycles", 64'(cyc), 64'(H * V + (V - 1) * GAPC));
    idle_chk("hramp_idle");

    // vertical ramp with random backpressure
    pattern_sel = 2'd2; enable = 1'b1; tick(); enable = 1'b0;
    run_frame(2'd2, 1'b1, 0, -1, 1'b0, 2'd0, cyc);
    end_of_frame("vramp_stall");
    idle_chk("vramp_idle");

    // enable held: checkerboard, then pattern 0 (changed mid-frame), then
    // pattern 1 (changed mid-frame), enable dropped at beat 10 of the last
    pattern_sel = 2'd3; enable = 1'b1; tick();
    run_frame(2'd3, 1'b0, 0, 20, 1'b1, 2'd0, cyc);
    end_of_frame("checker");
    run_frame(2'd0, 1'b0, GAPC, -1, 1'b1, 2'd0, cyc);
    end_of_frame("b2b_solid");
    chk("b2b_spacing1", 64'(cyc), 64'(H * V + V * GAPC));
    run_frame(2'd0, 1'b0, GAPC, 30, 1'b1, 2'd1, cyc);
    end_of_frame("b2b_solid2");
    chk("b2b_spacing2", 64'(cyc), 64'(H * V + V * GAPC));
    run_frame(2'd1, 1'b0, GAPC, 10, 1'b0, 2'd1, cyc);
    end_of_frame("drop_en");
    idle_chk("drop_en_idle");

    // asynchronous reset while beat 13 of a frame is on the bus
    pattern_sel = 2'd1; enable = 1'b1; tick();
    repeat (13) tick();
    chk("pre_rst_beat", {m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata},
        {1'b1, 1'b0, 1'b0, 24'h0D0D0D});
    rst_n = 1'b0; #2;
    chk("async_rst_out", {frame_done, m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata}, 64'd0);
    chk("async_rst_cnt", 64'(frame_cnt), 64'd0);
    fcnt = 0;
    @(posedge clk); #1; rst_n = 1'b1;
    tick();
    run_frame(2'd1, 1'b0, 0, 0, 1'b0, 2'd1, cyc);
    end_of_frame("post_rst");
    idle_chk("post_rst_idle");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
